// File: rtl/cam_search_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : cam_search_engine_if
// Purpose  : Stream request/response bundle for the CAM search engine.
// Revision : 1.0
// ============================================================================
interface cam_search_engine_if #(
    parameter int DATA_WIDTH    = 512,
    parameter int OP_CODE_WIDTH = 3
);
    logic [OP_CODE_WIDTH-1:0] state;
    logic                     s_tvalid;
    logic                     s_tready;
    logic [DATA_WIDTH-1:0]    s_tdata;
    logic                     m_tvalid;
    logic                     m_tready;
    logic [DATA_WIDTH-1:0]    m_tdata;
    logic                     update_all_end;

    modport master (
        output state, s_tvalid, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_tdata, update_all_end
    );

    modport slave (
        input  state, s_tvalid, s_tdata, m_tready,
        output s_tready, m_tvalid, m_tdata, update_all_end
    );
endinterface
`default_nettype wire

// File: rtl/cam_search_engine.sv
`default_nettype none
// ============================================================================
// Module   : cam_search_engine
// Purpose  : Pipelined CAM with bulk/single updates and lowest-index search.
// Revision : 1.0
// ============================================================================
module cam_search_engine #(
    parameter int DATA_WIDTH     = 512,
    parameter int KEY_WIDTH      = 32,
    parameter int CAM_SIZE       = 256,
    parameter int WORDS_PER_BEAT = DATA_WIDTH / KEY_WIDTH,
    parameter int DIVISION       = 2,
    parameter int OP_CODE_WIDTH  = 3,
    parameter int INDEX_WIDTH    = $clog2(CAM_SIZE)
) (
    input  wire logic          aclk,
    input  wire logic          aresetn,
    cam_search_engine_if.slave bus
);

    localparam int SEG_SIZE  = CAM_SIZE / DIVISION;
    localparam int SEG_CNT_W = $clog2(SEG_SIZE + 1);

    localparam logic [OP_CODE_WIDTH-1:0] c_OP_UPDATE_ALL = OP_CODE_WIDTH'(1);
    localparam logic [OP_CODE_WIDTH-1:0] c_OP_SEARCH     = OP_CODE_WIDTH'(2);
    localparam logic [OP_CODE_WIDTH-1:0] c_OP_UPDATE_ONE = OP_CODE_WIDTH'(3);
    localparam logic [INDEX_WIDTH-1:0]   c_LAST_PTR      = INDEX_WIDTH'(CAM_SIZE - WORDS_PER_BEAT);
    localparam logic [INDEX_WIDTH-1:0]   c_PTR_STEP      = INDEX_WIDTH'(WORDS_PER_BEAT);

    // Table
    logic [KEY_WIDTH-1:0]   r_key [CAM_SIZE];
    logic [CAM_SIZE-1:0]    r_valid;
    logic [INDEX_WIDTH-1:0] r_write_ptr;

    // Stage 1
    logic                   r_s1_resp;
    logic                   r_s1_search;
    logic [6:0]             r_s1_code;
    logic [KEY_WIDTH-1:0]   r_s1_key;

    // Stage 2
    logic                   r_s2_resp;
    logic                   r_s2_search;
    logic [6:0]             r_s2_code;
    logic [DIVISION-1:0]    r_s2_found;
    logic [INDEX_WIDTH-1:0] r_s2_idx [DIVISION];
    logic [SEG_CNT_W-1:0]   r_s2_cnt [DIVISION];

    // Output register
    logic                   r_m_tvalid;
    logic [DATA_WIDTH-1:0]  r_m_tdata;

    logic                   w_advance;
    logic                   w_accept;
    logic                   w_do_all;
    logic                   w_do_one;
    logic                   w_wrap;
    logic [KEY_WIDTH-1:0]   w_in_key;
    logic [INDEX_WIDTH-1:0] w_in_idx;
    logic                   w_in_inv;
    logic [CAM_SIZE-1:0]    w_all_we;
    logic [CAM_SIZE-1:0]    w_one_we;
    logic [CAM_SIZE-1:0]    w_one_clr;
    logic [CAM_SIZE-1:0]    w_match;
    logic [DIVISION-1:0]    w_seg_found;
    logic [INDEX_WIDTH-1:0] w_seg_idx [DIVISION];
    logic [SEG_CNT_W-1:0]   w_seg_cnt [DIVISION];
    logic [INDEX_WIDTH:0]   w_hit_idx;
    logic [31:0]            w_cnt_sum;
    logic [15:0]            w_cnt_sat;
    logic [DATA_WIDTH-1:0]  w_resp_data;

    assign w_advance = !r_m_tvalid || bus.m_tready;
    assign w_accept  = w_advance && bus.s_tvalid;
    assign w_do_all  = w_accept && (bus.state == c_OP_UPDATE_ALL);
    assign w_do_one  = w_accept && (bus.state == c_OP_UPDATE_ONE);
    assign w_wrap    = w_do_all && (r_write_ptr == c_LAST_PTR);
    assign w_in_key  = bus.s_tdata[KEY_WIDTH-1:0];
    assign w_in_idx  = bus.s_tdata[KEY_WIDTH +: INDEX_WIDTH];
    assign w_in_inv  = bus.s_tdata[DATA_WIDTH-1];

    assign bus.s_tready       = w_advance;
    assign bus.update_all_end = w_wrap && aresetn;
    assign bus.m_tvalid       = r_m_tvalid;
    assign bus.m_tdata        = r_m_tdata;

    // Per-entry write decode; a bulk beat covers the aligned block at write_ptr.
    always_comb begin
        w_all_we  = '0;
        w_one_we  = '0;
        w_one_clr = '0;
        for (int i = 0; i < CAM_SIZE; i++) begin
            w_all_we[i]  = w_do_all &&
                           (r_write_ptr == INDEX_WIDTH'((i / WORDS_PER_BEAT) * WORDS_PER_BEAT));
            w_one_we[i]  = w_do_one && !w_in_inv && (w_in_idx == INDEX_WIDTH'(i));
            w_one_clr[i] = w_do_one &&  w_in_inv && (w_in_idx == INDEX_WIDTH'(i));
        end
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < CAM_SIZE; i++) begin
            if (w_all_we[i]) begin
                r_key[i] <= bus.s_tdata[(i % WORDS_PER_BEAT) * KEY_WIDTH +: KEY_WIDTH];
            end else if (w_one_we[i]) begin
                r_key[i] <= w_in_key;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid     <= '0;
            r_write_ptr <= '0;
        end else begin
            for (int i = 0; i < CAM_SIZE; i++) begin
                if (w_all_we[i] || w_one_we[i]) begin
                    r_valid[i] <= 1'b1;
                end else if (w_one_clr[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_do_all) begin
                r_write_ptr <= w_wrap ? '0 : r_write_ptr + c_PTR_STEP;
            end
        end
    end

    // S1: capture opcode decision and the search key
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_s1_resp   <= 1'b0;
            r_s1_search <= 1'b0;
            r_s1_code   <= '0;
            r_s1_key    <= '0;
        end else if (w_advance) begin
            r_s1_resp   <= w_wrap || w_do_one ||
                           (w_accept && (bus.state == c_OP_SEARCH));
            r_s1_search <= w_accept && (bus.state == c_OP_SEARCH);
            r_s1_code   <= w_do_one ? (w_in_inv ? 7'd102 : 7'd101) : 7'd100;
            r_s1_key    <= w_in_key;
        end
    end

    // S2: compare against the table as written by all earlier beats
    always_comb begin
        w_match = '0;
        for (int i = 0; i < CAM_SIZE; i++) begin
            w_match[i] = r_valid[i] && (r_key[i] == r_s1_key);
        end
    end

    // Scan high-to-low so the lowest matching index is the last one kept
    always_comb begin
        for (int d = 0; d < DIVISION; d++) begin
            w_seg_found[d] = 1'b0;
            w_seg_idx[d]   = '0;
            w_seg_cnt[d]   = '0;
            for (int j = SEG_SIZE - 1; j >= 0; j--) begin
                if (w_match[d * SEG_SIZE + j]) begin
                    w_seg_found[d] = 1'b1;
                    w_seg_idx[d]   = INDEX_WIDTH'(d * SEG_SIZE + j);
                    w_seg_cnt[d]   = w_seg_cnt[d] + SEG_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_s2_resp   <= 1'b0;
            r_s2_search <= 1'b0;
            r_s2_code   <= '0;
            r_s2_found  <= '0;
            for (int d = 0; d < DIVISION; d++) begin
                r_s2_idx[d] <= '0;
                r_s2_cnt[d] <= '0;
            end
        end else if (w_advance) begin
            r_s2_resp   <= r_s1_resp;
            r_s2_search <= r_s1_search;
            r_s2_code   <= r_s1_code;
            r_s2_found  <= w_seg_found;
            for (int d = 0; d < DIVISION; d++) begin
                r_s2_idx[d] <= w_seg_idx[d];
                r_s2_cnt[d] <= w_seg_cnt[d];
            end
        end
    end

    // S3: merge segments, lowest segment with a hit wins
    always_comb begin
        w_hit_idx = '1;
        w_cnt_sum = '0;
        for (int d = DIVISION - 1; d >= 0; d--) begin
            if (r_s2_found[d]) begin
                w_hit_idx = {1'b0, r_s2_idx[d]};
            end
            w_cnt_sum = w_cnt_sum + 32'(r_s2_cnt[d]);
        end
        w_cnt_sat   = (w_cnt_sum > 32'h0000_FFFF) ? 16'hFFFF : w_cnt_sum[15:0];
        w_resp_data = '0;
        if (r_s2_search) begin
            w_resp_data[INDEX_WIDTH:0] = w_hit_idx;
            w_resp_data[47:32]         = w_cnt_sat;
        end else begin
            w_resp_data[6:0] = r_s2_code;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
        end else if (w_advance) begin
            r_m_tvalid <= r_s2_resp;
            if (r_s2_resp) begin
                r_m_tdata <= w_resp_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_search_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_search_engine
// Purpose  : Self-checking bench for cam_search_engine against a table model.
// Revision : 1.0
// ============================================================================
module tb_cam_search_engine;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;

    cam_search_engine_if #(.DATA_WIDTH(512), .OP_CODE_WIDTH(3)) bus ();

    cam_search_engine dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus.slave)
    );

    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference table
    logic [31:0] mkey [256];
    bit          mvalid [256];
    int          mptr;

    logic [511:0] exp_q [$];
    logic [511:0] got_q [$];
    int           got_cyc [$];
    int           pulse_cyc [$];

    function automatic logic [511:0] sresp(input int idx, input int cnt);
        logic [511:0] r;
        r = '0;
        r[8:0]   = (idx < 0) ? 9'h1FF : 9'(idx);
        r[47:32] = (cnt > 65535) ? 16'hFFFF : 16'(cnt);
        return r;
    endfunction

    function automatic logic [511:0] upd(input int idx, input logic [31:0] key, input bit inv);
        logic [511:0] d;
        d = '0;
        d[31:0]  = key;
        d[39:32] = 8'(idx);
        d[511]   = inv;
        return d;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
        mptr = 0;
    endtask

    task automatic model_beat(input logic [2:0] op, input logic [511:0] d);
        int lo;
        int cnt;
        int idx;
        case (op)
            3'd1: begin
                for (int k = 0; k < 16; k++) begin
                    mkey[mptr + k]   = d[k*32 +: 32];
                    mvalid[mptr + k] = 1'b1;
                end
                if (mptr == 240) begin
                    mptr = 0;
                    exp_q.push_back(512'd100);
                end else begin
                    mptr = mptr + 16;
                end
            end
            3'd3: begin
                idx = int'(d[39:32]);
                if (d[511]) begin
                    mvalid[idx] = 1'b0;
                    exp_q.push_back(512'd102);
                end else begin
                    mkey[idx]   = d[31:0];
                    mvalid[idx] = 1'b1;
                    exp_q.push_back(512'd101);
                end
            end
            3'd2: begin
                lo  = -1;
                cnt = 0;
                for (int i = 0; i < 256; i++) begin
                    if (mvalid[i] && mkey[i] == d[31:0]) begin
                        if (lo < 0) lo = i;
                        cnt++;
                    end
                end
                exp_q.push_back(sresp(lo, cnt));
            end
            default: ;
        endcase
    endtask

    // One clock: observe pre-edge handshakes, then step to just after the edge
    task automatic cycle(output bit acc);
        #1;
        acc = bus.s_tvalid && bus.s_tready;
        if (acc) model_beat(bus.state, bus.s_tdata);
        if (bus.update_all_end) pulse_cyc.push_back(cyc);
        if (bus.m_tvalid && bus.m_tready) begin
            got_q.push_back(bus.m_tdata);
            got_cyc.push_back(cyc);
        end
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [2:0] op, input logic [511:0] d, output int acc_cyc);
        bit acc;
        acc_cyc     = -1;
        bus.state    = op;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = d;
        for (int t = 0; t < 64; t++) begin
            acc_cyc = cyc;
            cycle(acc);
            if (acc) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: beat not accepted, got s_tready=%0b, need 1", bus.s_tready);
    endtask

    task automatic idle(input int n);
        bit acc;
        bus.s_tvalid = 1'b0;
        repeat (n) cycle(acc);
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        pulse_cyc.delete();
    endtask

    function automatic logic [511:0] load_beat(input int base);
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = 32'(base + k);
        return d;
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        model_reset();
        bus.state    = '0;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.m_tready = 1'b1;
        aresetn      = 1'b0;
        @(posedge aclk);
        @(posedge aclk);
        #1;
        n_tests++;
        if (bus.m_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_m_tvalid: got %0b, need 0", bus.m_tvalid);
        end
        n_tests++;
        if (bus.m_tdata !== '0) begin
            n_fail++; $display("FAIL reset_m_tdata: got %0h, need 0", bus.m_tdata);
        end
        n_tests++;
        if (bus.update_all_end !== 1'b0) begin
            n_fail++; $display("FAIL reset_update_all_end: got %0b, need 0", bus.update_all_end);
        end
        aresetn = 1'b1;
        idle(2);
    endtask

    task automatic test_bulk_load();
        int ac;
        int a15;
        clear_q();
        a15 = -1;
        for (int b = 0; b < 16; b++) begin
            send(3'd1, load_beat(b * 16 + 'h1000), ac);
            if (b == 15) a15 = ac;
        end
        idle(6);
        n_tests++;
        if (pulse_cyc.size() != 1 || pulse_cyc[0] != a15) begin
            n_fail++; $display("FAIL load_pulse: got %0d pulses (first at %0d), need 1 at %0d",
                               pulse_cyc.size(), (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1, a15);
        end
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== 512'd100) begin
            n_fail++; $display("FAIL load_resp: got %0d responses (first %0h), need one of 100",
                               got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end
        n_tests++;
        if (got_cyc.size() < 1 || got_cyc[0] != a15 + 3) begin
            n_fail++; $display("FAIL load_latency: got cycle %0d, need %0d",
                               (got_cyc.size() > 0) ? got_cyc[0] : -1, a15 + 3);
        end
    endtask

    task automatic test_search_b2b();
        int a0;
        int ac;
        logic [511:0] need [3];
        need[0] = sresp(5, 1);
        need[1] = sresp(255, 1);
        need[2] = sresp(-1, 0);
        clear_q();
        send(3'd2, 512'h1005, a0);
        send(3'd2, 512'h10FF, ac);
        send(3'd2, 512'h2000, ac);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (got_q.size() <= i || got_q[i] !== need[i] || got_cyc[i] != a0 + 3 + i) begin
                n_fail++; $display("FAIL search_b2b[%0d]: got %0h at cycle %0d, need %0h at %0d", i,
                                   (got_q.size() > i) ? got_q[i] : '0,
                                   (got_q.size() > i) ? got_cyc[i] : -1, need[i], a0 + 3 + i);
            end
        end
    endtask

    task automatic test_update_one();
        int ac;
        logic [511:0] need [4];
        need[0] = 512'd101;
        need[1] = sresp(5, 2);
        need[2] = 512'd102;
        need[3] = sresp(200, 1);
        clear_q();
        send(3'd3, upd(200, 32'h1005, 1'b0), ac);
        send(3'd2, 512'h1005, ac);
        send(3'd3, upd(5, 32'h0, 1'b1), ac);
        send(3'd2, 512'h1005, ac);
        idle(6);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (got_q.size() <= i || got_q[i] !== need[i]) begin
                n_fail++; $display("FAIL update_one[%0d]: got %0h, need %0h", i,
                                   (got_q.size() > i) ? got_q[i] : '0, need[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0]  keys [5];
        logic [511:0] need [5];
        logic [511:0] held;
        bit held_ok;
        bit stable;
        bit acc;
        int p;
        int ac;
        keys[0] = 32'h1010; need[0] = sresp(16, 1);
        keys[1] = 32'h1020; need[1] = sresp(32, 1);
        keys[2] = 32'h10FE; need[2] = sresp(254, 1);
        keys[3] = 32'h3333; need[3] = sresp(-1, 0);
        keys[4] = 32'h1000; need[4] = sresp(0, 1);
        clear_q();
        p       = 0;
        stable  = 1'b1;
        held_ok = 1'b0;
        held    = '0;
        bus.m_tready = 1'b0;
        bus.state    = 3'd2;
        for (int c = 0; c < 10; c++) begin
            bus.s_tvalid = (p < 5);
            bus.s_tdata  = '0;
            if (p < 5) bus.s_tdata[31:0] = keys[p];
            cycle(acc);
            if (acc) p++;
            if (bus.m_tvalid) begin
                if (held_ok && bus.m_tdata !== held) stable = 1'b0;
                held    = bus.m_tdata;
                held_ok = 1'b1;
            end
        end
        n_tests++;
        if (p != 3 || bus.s_tready !== 1'b0) begin
            n_fail++; $display("FAIL stall_fill: got %0d accepted, s_tready=%0b; need 3, 0", p, bus.s_tready);
        end
        n_tests++;
        if (!stable || !held_ok || held !== need[0]) begin
            n_fail++; $display("FAIL stall_hold: got %0h (stable=%0b), need %0h stable", held, stable, need[0]);
        end
        bus.m_tready = 1'b1;
        while (p < 5) begin
            send(3'd2, {480'd0, keys[p]}, ac);
            p++;
        end
        idle(8);
        n_tests++;
        if (got_q.size() != 5) begin
            n_fail++; $display("FAIL stall_count: got %0d responses, need 5", got_q.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (got_q.size() <= i || got_q[i] !== need[i]) begin
                n_fail++; $display("FAIL stall_order[%0d]: got %0h, need %0h", i,
                                   (got_q.size() > i) ? got_q[i] : '0, need[i]);
            end
        end
    endtask

    task automatic test_reset_midop();
        int ac;
        bit acc;
        logic [511:0] need [2];
        clear_q();
        for (int b = 0; b < 7; b++) send(3'd1, load_beat('hA000 + b * 16), ac);
        send(3'd2, 512'hA003, ac);
        idle(5);
        n_tests++;
        if (got_q.size() != 1 || got_q[0] !== sresp(3, 1)) begin
            n_fail++; $display("FAIL reload_from_zero: got %0h, need %0h",
                               (got_q.size() > 0) ? got_q[0] : '0, sresp(3, 1));
        end
        send(3'd2, 512'hA010, ac);
        send(3'd2, 512'hA020, ac);
        send(3'd1, load_beat('hA000 + 7 * 16), ac);
        bus.s_tvalid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        n_tests++;
        if (bus.m_tvalid !== 1'b0 || bus.m_tdata !== '0 || bus.update_all_end !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got m_tvalid=%0b m_tdata=%0h end=%0b, need all 0",
                               bus.m_tvalid, bus.m_tdata, bus.update_all_end);
        end
        model_reset();
        clear_q();
        @(posedge aclk);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        need[0] = sresp(-1, 0);
        need[1] = sresp(2, 1);
        send(3'd2, 512'h1000, ac);
        send(3'd1, load_beat('hB000), ac);
        send(3'd2, 512'hB002, ac);
        idle(6);
        n_tests++;
        if (got_q.size() != 2 || pulse_cyc.size() != 0) begin
            n_fail++; $display("FAIL post_reset_count: got %0d responses %0d pulses, need 2 and 0",
                               got_q.size(), pulse_cyc.size());
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (got_q.size() <= i || got_q[i] !== need[i]) begin
                n_fail++; $display("FAIL post_reset[%0d]: got %0h, need %0h", i,
                                   (got_q.size() > i) ? got_q[i] : '0, need[i]);
            end
        end
    endtask

    task automatic test_random_mix();
        logic [511:0] d;
        logic [2:0]   op;
        bit pending;
        bit acc;
        int sent;
        int guard;
        int r;
        clear_q();
        pending = 1'b0;
        sent    = 0;
        guard   = 0;
        op      = '0;
        d       = '0;
        while (sent < 150 && guard < 3000) begin
            if (!pending) begin
                for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
                r = $urandom_range(0, 7);
                if (r < 2) begin
                    op = 3'd0;
                end else if (r == 2) begin
                    op = 3'($urandom_range(4, 7));
                end else if (r < 7) begin
                    op = 3'd2;
                    if ($urandom_range(0, 1) == 1) d[31:0] = 32'hB000 + 32'($urandom_range(0, 19));
                end else begin
                    op = 3'd3;
                    d[31:0]  = 32'hB000 + 32'($urandom_range(0, 15));
                    d[39:32] = 8'($urandom_range(0, 31));
                end
                pending = 1'b1;
            end
            bus.m_tready = ($urandom_range(0, 3) != 0);
            bus.s_tvalid = ($urandom_range(0, 4) != 0);
            bus.state    = op;
            bus.s_tdata  = d;
            cycle(acc);
            if (acc) begin
                sent++;
                pending = 1'b0;
            end
            guard++;
        end
        n_tests++;
        if (sent != 150) begin
            n_fail++; $display("FAIL random_progress: got %0d beats accepted, need 150", sent);
        end
        bus.m_tready = 1'b1;
        idle(10);
        n_tests++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL random_count: got %0d responses, need %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_tests++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL random_resp[%0d]: got %0h, need %0h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bulk_load();
        test_search_b2b();
        test_update_one();
        test_backpressure();
        test_reset_midop();
        test_random_mix();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, need completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
